instr_source_ctrl: RTL and testbench

//   Front-panel instruction-source and execution controller between ROM32k, the board switches/buttons and the CPU.

---
 rtl/instr_source_ctrl.sv | 144 ++++++++++++++
 tb/tb_instr_source_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/instr_source_ctrl.sv
// Front-panel controller: debounces mode/step buttons, cycles ROM_RUN/ROM_STEP/MANUAL,
// selects the CPU instruction source and generates the CPU clock enable.
module instr_source_ctrl #(
    parameter int unsigned INSTR_W         = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 16'd50000,
    parameter int unsigned DB_W            = 16,
    parameter int unsigned RUN_DIV         = 1,
    parameter int unsigned DIV_W           = 8,
    parameter int unsigned CNT_W           = 16
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               mode_btn,
    input  logic               step_btn,
    input  logic [INSTR_W-1:0] switches,
    input  logic [INSTR_W-1:0] rom_instr,
    output logic [INSTR_W-1:0] instr_out,
    output logic               cpu_ce,
    output logic [1:0]         mode,
    output logic [2:0]         mode_led,
    output logic [CNT_W-1:0]   instr_count
);

    localparam logic [1:0] MODE_RUN    = 2'd0;
    localparam logic [1:0] MODE_STEP   = 2'd1;
    localparam logic [1:0] MODE_MANUAL = 2'd2;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    // Bit 0 is the mode button, bit 1 the step button
    logic [1:0]           raw_btn;
    logic [1:0]           sync1_q, sync2_q;
    logic [1:0]           stable_q, stable_d;
    logic [1:0]           press_q, press_d;
    logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;

    logic [1:0]           mode_q, mode_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 cpu_ce_q, cpu_ce_d;
    logic [INSTR_W-1:0]   latch_q, latch_d;
    logic                 pending_q, pending_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 mode_ev, step_ev;

    assign raw_btn = {step_btn, mode_btn};

    // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing edges
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            stable_d[b] = stable_q[b];
            db_cnt_d[b] = '0;
            if (sync2_q[b] != stable_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    stable_d[b] = sync2_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + 1'b1;
                end
            end
        end
        press_d = stable_d & ~stable_q;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            press_q  <= '0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= raw_btn;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign mode_ev = press_q[0];
    assign step_ev = press_q[1];

    // A mode event overrides everything, so a simultaneous step event is dropped
    always_comb begin
        mode_d    = mode_q;
        div_d     = div_q;
        cpu_ce_d  = 1'b0;
        latch_d   = latch_q;
        pending_d = pending_q;
        count_d   = cpu_ce_q ? count_q + 1'b1 : count_q;
        if (mode_ev) begin
            case (mode_q)
                MODE_RUN:  mode_d = MODE_STEP;
                MODE_STEP: mode_d = MODE_MANUAL;
                default:   mode_d = MODE_RUN;
            endcase
            div_d     = '0;
            pending_d = 1'b0;
        end else begin
            case (mode_q)
                MODE_RUN: begin
                    cpu_ce_d = (div_q == DIV_LAST);
                    div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
                end
                MODE_STEP: cpu_ce_d = step_ev;
                MODE_MANUAL: begin
                    if (pending_q) begin
                        cpu_ce_d  = 1'b1;
                        pending_d = 1'b0;
                    end else if (step_ev) begin
                        latch_d   = switches;
                        pending_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            mode_q    <= MODE_RUN;
            div_q     <= '0;
            cpu_ce_q  <= 1'b0;
            latch_q   <= '0;
            pending_q <= 1'b0;
            count_q   <= '0;
        end else begin
            mode_q    <= mode_d;
            div_q     <= div_d;
            cpu_ce_q  <= cpu_ce_d;
            latch_q   <= latch_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign mode        = mode_q;
    assign cpu_ce      = cpu_ce_q;
    assign instr_count = count_q;
    assign mode_led    = {mode_q == MODE_MANUAL, mode_q == MODE_STEP, mode_q == MODE_RUN};
    assign instr_out   = (mode_q == MODE_MANUAL) ? latch_q : rom_instr;

endmodule

// File: tb/tb_instr_source_ctrl.sv
// Directed bench for instr_source_ctrl with short debounce (4), RUN_DIV=3 and a 4-bit counter.
module tb_instr_source_ctrl;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        mode_btn;
    logic        step_btn;
    logic [15:0] switches;
    logic [15:0] rom_instr;
    logic [15:0] instr_out;
    logic        cpu_ce;
    logic [1:0]  mode;
    logic [2:0]  mode_led;
    logic [3:0]  instr_count;

    int assertCount = 0;
    int failCount   = 0;

    instr_source_ctrl #(
        .INSTR_W(16), .DEBOUNCE_CYCLES(4), .DB_W(16),
        .RUN_DIV(3), .DIV_W(8), .CNT_W(4)
    ) dut (
        .clk_in(clk_in), .reset(reset), .mode_btn(mode_btn), .step_btn(step_btn),
        .switches(switches), .rom_instr(rom_instr), .instr_out(instr_out),
        .cpu_ce(cpu_ce), .mode(mode), .mode_led(mode_led), .instr_count(instr_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Holds the mode button 10 cycles; the new mode must appear exactly at edge 7
    task automatic pressMode(input logic [1:0] expOld, input logic [1:0] expNew);
        logic [2:0] expLed;
        expLed = 3'b001 << expNew;
        mode_btn = 1'b1;
        applyStimulus(6);
        checkOutput("mode_before_edge7", 32'(mode), 32'(expOld));
        applyStimulus(1);
        checkOutput("mode_at_edge7", 32'(mode), 32'(expNew));
        checkOutput("mode_led", 32'(mode_led), 32'(expLed));
        applyStimulus(3);
        mode_btn = 1'b0;
        applyStimulus(12);
        checkOutput("mode_after_release", 32'(mode), 32'(expNew));
    endtask

    task automatic pressStep(input int ceTick, input logic [15:0] swAfter, input logic [15:0] expInstr);
        step_btn = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            applyStimulus(1);
            checkOutput("step_ce", 32'(cpu_ce), 32'(t == ceTick));
            if (t == 7) switches = swAfter;
        end
        step_btn = 1'b0;
        for (int t = 0; t < 12; t++) begin
            applyStimulus(1);
            checkOutput("release_ce", 32'(cpu_ce), 32'd0);
        end
        checkOutput("instr_hold", 32'(instr_out), 32'(expInstr));
    endtask

    initial begin
        logic       prevCe;
        logic       expCe;
        logic [3:0] expCount;
        logic [3:0] baseCount;

        reset     = 1'b1;
        mode_btn  = 1'b0;
        step_btn  = 1'b0;
        switches  = 16'hEC10;
        rom_instr = 16'h1234;
        applyStimulus(2);
        checkOutput("reset_mode", 32'(mode), 32'd0);
        checkOutput("reset_ce", 32'(cpu_ce), 32'd0);
        checkOutput("reset_count", 32'(instr_count), 32'd0);
        checkOutput("reset_led", 32'(mode_led), 32'b001);
        checkOutput("reset_instr", 32'(instr_out), 32'h1234);
        reset = 1'b0;

        // ROM_RUN: a pulse every third cycle, counter wraps after 16 pulses
        prevCe   = 1'b0;
        expCount = 4'd0;
        for (int n = 1; n <= 50; n++) begin
            applyStimulus(1);
            if (prevCe) expCount = expCount + 4'd1;
            expCe = (n % 3 == 0);
            checkOutput("run_ce", 32'(cpu_ce), 32'(expCe));
            checkOutput("run_count", 32'(instr_count), 32'(expCount));
            if (n == 46) checkOutput("run_count_15", 32'(instr_count), 32'd15);
            if (n == 49) checkOutput("run_count_wrap", 32'(instr_count), 32'd0);
            prevCe = expCe;
        end
        checkOutput("run_instr", 32'(instr_out), 32'h1234);

        // Three-cycle glitch is one edge short of acceptance
        mode_btn = 1'b1;
        applyStimulus(3);
        mode_btn = 1'b0;
        for (int t = 0; t < 12; t++) begin
            applyStimulus(1);
            checkOutput("glitch_mode", 32'(mode), 32'd0);
        end

        pressMode(2'd0, 2'd1);
        pressMode(2'd1, 2'd2);
        pressMode(2'd2, 2'd0);

        // ROM_STEP: one pulse per press
        pressMode(2'd0, 2'd1);
        baseCount = instr_count;
        pressStep(7, 16'hEC10, 16'h1234);
        pressStep(7, 16'hEC10, 16'h1234);
        checkOutput("step_count", 32'(instr_count), 32'(4'(baseCount + 4'd2)));

        // MANUAL: latched word, pulse one cycle after the pending cycle
        pressMode(2'd1, 2'd2);
        checkOutput("manual_latch_init", 32'(instr_out), 32'h0000);
        baseCount = instr_count;
        pressStep(8, 16'h0000, 16'hEC10);
        checkOutput("manual_count", 32'(instr_count), 32'(4'(baseCount + 4'd1)));

        // Reset during the pending cycle aborts the execute
        switches = 16'h5555;
        step_btn = 1'b1;
        applyStimulus(7);
        checkOutput("pending_latch", 32'(instr_out), 32'h5555);
        checkOutput("pending_ce", 32'(cpu_ce), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("abort_mode", 32'(mode), 32'd0);
        checkOutput("abort_count", 32'(instr_count), 32'd0);
        checkOutput("abort_instr", 32'(instr_out), 32'h1234);
        for (int t = 0; t < 3; t++) begin
            applyStimulus(1);
            checkOutput("abort_ce", 32'(cpu_ce), 32'd0);
        end
        step_btn = 1'b0;
        applyStimulus(10);
        reset = 1'b0;
        applyStimulus(1);
        checkOutput("post_abort_mode", 32'(mode), 32'd0);
        checkOutput("post_abort_count", 32'(instr_count), 32'd0);

        // Simultaneous mode and step events: mode advances, step discarded
        pressMode(2'd0, 2'd1);
        switches  = 16'hABCD;
        baseCount = instr_count;
        mode_btn  = 1'b1;
        step_btn  = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            applyStimulus(1);
            checkOutput("both_ce", 32'(cpu_ce), 32'd0);
            if (t == 6) checkOutput("both_mode_before", 32'(mode), 32'd1);
            if (t == 7) checkOutput("both_mode_after", 32'(mode), 32'd2);
        end
        mode_btn = 1'b0;
        step_btn = 1'b0;
        for (int t = 0; t < 12; t++) begin
            applyStimulus(1);
            checkOutput("both_release_ce", 32'(cpu_ce), 32'd0);
        end
        checkOutput("both_final_mode", 32'(mode), 32'd2);
        checkOutput("both_instr", 32'(instr_out), 32'h0000);
        checkOutput("both_count", 32'(instr_count), 32'(baseCount));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
